// File: rtl/control_unit_pkg.sv
// control_unit_pkg: control encodings shared between decode and execute.
//   regsel_t - register write-back source select
//   FWD_REG  - forward-select value meaning "use the register-file operand"
package control_unit_pkg;

  typedef enum logic [1:0] {
    RSEL_ALU = 2'd0,
    RSEL_MEM = 2'd1,
    RSEL_NPC = 2'd2,
    RSEL_LUI = 2'd3
  } regsel_t;

  localparam int FWD_REG = 0;

endpackage

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types for the pipelined MIPS core.
//   word_t   - 32-bit machine word
//   regbit_t - register-file index
//   aluop_t  - ALU operation, including ALU_MUL for the iterative multiplier
//   alusrc_t - ALU B-operand source select
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbit_t;

  typedef enum logic [3:0] {
    ALU_SLL,
    ALU_SRL,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_MUL
  } aluop_t;

  typedef enum logic {
    SRC_REG = 1'b0,
    SRC_IMM = 1'b1
  } alusrc_t;

endpackage

// File: rtl/execute_stage_alu.sv
// alu: combinational ALU for the execute stage.
// Ports:
//   a, b    in  WORD_W  operands (shifts operate on b)
//   shamt   in  SHAM_W  shift amount
//   aluop   in  aluop_t operation
//   result  out WORD_W  result, modulo 2^WORD_W; ALU_MUL yields 0 here
module alu
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int SHAM_W = 5
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [SHAM_W-1:0] shamt,
  input  aluop_t            aluop,
  output logic [WORD_W-1:0] result
);

  logic w_slt;
  logic w_sltu;

  assign w_slt  = $signed(a) < $signed(b);
  assign w_sltu = a < b;

  always_comb begin
    result = '0;
    case (aluop)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {{(WORD_W-1){1'b0}}, w_slt};
      ALU_SLTU: result = {{(WORD_W-1){1'b0}}, w_sltu};
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// execute_stage: EX stage of the pipelined MIPS datapath. Forwards operands
// from NFWD later-stage sources, runs the ALU, resolves branch-equal and
// registers everything into the EX/MEM latch with flush/stall control.
// Optional iterative shift-add multiplier enabled by macro EXEC_MULT_EN;
// while it runs, ex_busy stalls the front of the pipeline.
// Ports:
//   CLK, RST                 clock (rising), async active-high reset
//   ihit, flush              advance enable, bubble insertion
//   npc/dren/dwen/regwr/regsel/regdst   ID/EX pass-through fields
//   rdat1, rdat2, imm, shamt operands
//   aluop, alusrc            operation, B source
//   fwd_sel_a/b, fwd_data    forwarding selects, packed forwarded values
//   *_next                   EX/MEM latch outputs
//   aluout_next, wdat_next   latched result and store data
//   equal                    combinational forwarded A == forwarded B
//   ex_busy                  combinational multi-cycle op in progress
module execute_stage
  import cpu_types_pkg::*;
  import control_unit_pkg::*;
#(
  parameter  int WORD_W = 32,
  parameter  int SHAM_W = 5,
  parameter  int NFWD   = 2,
  localparam int FSEL_W = $clog2(NFWD + 1)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ihit,
  input  logic                   flush,
  input  logic [WORD_W-1:0]      npc,
  input  logic                   dren,
  input  logic                   dwen,
  input  logic                   regwr,
  input  regsel_t                regsel,
  input  regbit_t                regdst,
  input  logic [WORD_W-1:0]      rdat1,
  input  logic [WORD_W-1:0]      rdat2,
  input  logic [WORD_W-1:0]      imm,
  input  logic [SHAM_W-1:0]      shamt,
  input  aluop_t                 aluop,
  input  alusrc_t                alusrc,
  input  logic [FSEL_W-1:0]      fwd_sel_a,
  input  logic [FSEL_W-1:0]      fwd_sel_b,
  input  logic [NFWD*WORD_W-1:0] fwd_data,
  output logic [WORD_W-1:0]      npc_next,
  output logic                   dren_next,
  output logic                   dwen_next,
  output logic                   regwr_next,
  output regsel_t                regsel_next,
  output regbit_t                regdst_next,
  output logic [WORD_W-1:0]      aluout_next,
  output logic [WORD_W-1:0]      wdat_next,
  output logic                   equal,
  output logic                   ex_busy
);

  logic [WORD_W-1:0] w_fwd_a;
  logic [WORD_W-1:0] w_fwd_b;
  logic [WORD_W-1:0] w_opb;
  logic [WORD_W-1:0] w_alu_b;
  logic [WORD_W-1:0] w_alu_result;
  logic [WORD_W-1:0] w_result;
  logic              w_busy;

  // Select FWD_REG (0) or any out-of-range value falls back to the register
  // operand; select k in 1..NFWD picks fwd_data slice k-1.
  always_comb begin
    w_fwd_a = rdat1;
    w_fwd_b = rdat2;
    for (int unsigned k = FWD_REG + 1; k <= NFWD; k++) begin
      if (fwd_sel_a == FSEL_W'(k)) w_fwd_a = fwd_data[(k-1)*WORD_W +: WORD_W];
      if (fwd_sel_b == FSEL_W'(k)) w_fwd_b = fwd_data[(k-1)*WORD_W +: WORD_W];
    end
  end

  assign w_opb = (alusrc == SRC_IMM) ? imm : w_fwd_b;
  assign equal = (w_fwd_a == w_fwd_b);

  // Shifts always act on the forwarded rt value, even when the B operand
  // mux is steering the immediate.
  assign w_alu_b = (aluop == ALU_SLL || aluop == ALU_SRL) ? w_fwd_b : w_opb;

  alu #(
    .WORD_W (WORD_W),
    .SHAM_W (SHAM_W)
  ) u_alu (
    .a      (w_fwd_a),
    .b      (w_alu_b),
    .shamt  (shamt),
    .aluop  (aluop),
    .result (w_alu_result)
  );

`ifdef EXEC_MULT_EN
  typedef enum logic [1:0] {IDLE, MUL, DONE} exec_state_t;

  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  exec_state_t       r_state;
  exec_state_t       w_state_next;
  logic [WORD_W-1:0] r_mcand;
  logic [WORD_W-1:0] r_mplier;
  logic [WORD_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        if (aluop == ALU_MUL && !flush) begin
          w_busy       = 1'b1;
          w_state_next = MUL;
        end
      end
      MUL: begin
        w_busy = 1'b1;
        if (flush)              w_state_next = IDLE;
        else if (r_count == '0) w_state_next = DONE;
      end
      DONE: begin
        if (ihit || flush) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (r_state == IDLE && w_state_next == MUL) begin
      r_mcand  <= w_fwd_a;
      r_mplier <= w_opb;
      r_acc    <= '0;
      r_count  <= CNT_W'(WORD_W - 1);
    end else if (r_state == MUL) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count - 1'b1;
    end
  end

  assign w_result = (r_state == DONE) ? r_acc : w_alu_result;
`else
  assign w_busy   = 1'b0;
  assign w_result = w_alu_result;
`endif

  assign ex_busy = w_busy;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      npc_next    <= '0;
      dren_next   <= 1'b0;
      dwen_next   <= 1'b0;
      regwr_next  <= 1'b0;
      regsel_next <= RSEL_ALU;
      regdst_next <= '0;
      aluout_next <= '0;
      wdat_next   <= '0;
    end else if (flush) begin
      npc_next    <= '0;
      dren_next   <= 1'b0;
      dwen_next   <= 1'b0;
      regwr_next  <= 1'b0;
      regsel_next <= RSEL_ALU;
      regdst_next <= '0;
      aluout_next <= '0;
      wdat_next   <= '0;
    end else if (ihit && !w_busy) begin
      npc_next    <= npc;
      dren_next   <= dren;
      dwen_next   <= dwen;
      regwr_next  <= regwr;
      regsel_next <= regsel;
      regdst_next <= regdst;
      aluout_next <= w_result;
      wdat_next   <= w_fwd_b;
    end else if (ihit) begin
      // Stall bubble: kill side effects, keep the data fields.
      dren_next  <= 1'b0;
      dwen_next  <= 1'b0;
      regwr_next <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
  import cpu_types_pkg::*;
  import control_unit_pkg::*;

  logic          CLK = 1'b0;
  logic          RST;
  logic          ihit, flush;
  logic [31:0]   npc;
  logic          dren, dwen, regwr;
  regsel_t       regsel;
  regbit_t       regdst;
  logic [31:0]   rdat1, rdat2, imm;
  logic [4:0]    shamt;
  aluop_t        aluop;
  alusrc_t       alusrc;
  logic [1:0]    fwd_sel_a, fwd_sel_b;
  logic [63:0]   fwd_data;
  logic [31:0]   npc_next;
  logic          dren_next, dwen_next, regwr_next;
  regsel_t       regsel_next;
  regbit_t       regdst_next;
  logic [31:0]   aluout_next, wdat_next;
  logic          equal, ex_busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  execute_stage #(
    .WORD_W (32),
    .SHAM_W (5),
    .NFWD   (2)
  ) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .flush(flush),
    .npc(npc), .dren(dren), .dwen(dwen), .regwr(regwr),
    .regsel(regsel), .regdst(regdst),
    .rdat1(rdat1), .rdat2(rdat2), .imm(imm), .shamt(shamt),
    .aluop(aluop), .alusrc(alusrc),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .fwd_data(fwd_data),
    .npc_next(npc_next), .dren_next(dren_next), .dwen_next(dwen_next),
    .regwr_next(regwr_next), .regsel_next(regsel_next),
    .regdst_next(regdst_next), .aluout_next(aluout_next),
    .wdat_next(wdat_next), .equal(equal), .ex_busy(ex_busy)
  );

  typedef struct {
    aluop_t      op;
    alusrc_t     src;
    logic [31:0] r1, r2, im;
    logic [4:0]  sh;
    logic [1:0]  sa, sb;
    logic [31:0] f1, f2;
    logic [31:0] exp_alu;
    logic        exp_eq;
  } vec_t;

  vec_t   vecs [12];
  aluop_t rops [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour written straight from the operation table.
  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] r,
                                      input logic [31:0] f1, input logic [31:0] f2);
    if (sel == 2'd1) return f1;
    if (sel == 2'd2) return f2;
    return r;
  endfunction

  function automatic logic [31:0] model_alu(input aluop_t op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] rb,
                                            input logic [4:0] sh);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  return rb << sh;
      ALU_SRL:  return rb >> sh;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic drive(input aluop_t op, input alusrc_t src, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] im, input logic [4:0] sh,
                       input logic [1:0] sa, input logic [1:0] sb,
                       input logic [31:0] f1, input logic [31:0] f2);
    aluop = op; alusrc = src; rdat1 = r1; rdat2 = r2; imm = im; shamt = sh;
    fwd_sel_a = sa; fwd_sel_b = sb; fwd_data = {f2, f1};
  endtask

  initial begin
    logic [31:0] ea, eb, ebo;
    logic [31:0] exp_alu, exp_wdat, exp_npc;
    logic        exp_regwr, ih, fl;
    int          busy_cycles;
    logic        bubble_ok;

    vecs[0]  = '{ALU_ADD,  SRC_REG, 32'd5,        32'd7,        32'd0,        5'd0,  2'd0, 2'd0, 32'd0,        32'd0,        32'd12,       1'b0};
    vecs[1]  = '{ALU_SUB,  SRC_REG, 32'd0,        32'd1,        32'd0,        5'd0,  2'd2, 2'd0, 32'd0,        32'hDEAD0000, 32'hDEACFFFF, 1'b0};
    vecs[2]  = '{ALU_SUB,  SRC_REG, 32'h100,      32'd1,        32'd0,        5'd0,  2'd3, 2'd0, 32'd0,        32'hDEAD0000, 32'h000000FF, 1'b0};
    vecs[3]  = '{ALU_SLT,  SRC_REG, 32'hFFFFFFFF, 32'd1,        32'd0,        5'd0,  2'd0, 2'd0, 32'd0,        32'd0,        32'd1,        1'b0};
    vecs[4]  = '{ALU_SLTU, SRC_REG, 32'hFFFFFFFF, 32'd1,        32'd0,        5'd0,  2'd0, 2'd0, 32'd0,        32'd0,        32'd0,        1'b0};
    vecs[5]  = '{ALU_XOR,  SRC_REG, 32'h10,       32'h10,       32'd0,        5'd0,  2'd0, 2'd0, 32'd0,        32'd0,        32'd0,        1'b1};
    vecs[6]  = '{ALU_SLL,  SRC_IMM, 32'd0,        32'd3,        32'h0000FFFF, 5'd4,  2'd0, 2'd0, 32'd0,        32'd0,        32'h30,       1'b0};
    vecs[7]  = '{ALU_SRL,  SRC_REG, 32'd0,        32'h80000000, 32'd0,        5'd31, 2'd0, 2'd0, 32'd0,        32'd0,        32'd1,        1'b0};
    vecs[8]  = '{ALU_NOR,  SRC_REG, 32'h0F0F0000, 32'h000000F0, 32'd0,        5'd0,  2'd0, 2'd0, 32'd0,        32'd0,        32'hF0F0FF0F, 1'b0};
    vecs[9]  = '{ALU_ADD,  SRC_IMM, 32'd10,       32'd99,       32'hFFFFFFFE, 5'd0,  2'd0, 2'd0, 32'd0,        32'd0,        32'd8,        1'b0};
    vecs[10] = '{ALU_AND,  SRC_REG, 32'h0FF00FF0, 32'd0,        32'd0,        5'd0,  2'd0, 2'd1, 32'hFF00FF00, 32'd0,        32'h0F000F00, 1'b0};
    vecs[11] = '{ALU_OR,   SRC_REG, 32'h1234,     32'h5600,     32'd0,        5'd0,  2'd0, 2'd0, 32'd0,        32'd0,        32'h5634,     1'b0};

    rops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
             ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL};

    // Reset state
    RST = 1'b1; ihit = 1'b0; flush = 1'b0;
    npc = '0; dren = 1'b0; dwen = 1'b0; regwr = 1'b0; regsel = RSEL_ALU; regdst = '0;
    drive(ALU_ADD, SRC_REG, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("reset_aluout", aluout_next, 32'd0);
    chk("reset_regwr", {31'd0, regwr_next}, 32'd0);
    chk("reset_npc", npc_next, 32'd0);
    chk("reset_busy", {31'd0, ex_busy}, 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      ihit = 1'b1; flush = 1'b0;
      npc = 32'h1000 + 32'(i) * 4; regwr = 1'b1; dren = i[0]; dwen = i[1];
      regsel = RSEL_MEM; regdst = regbit_t'(i);
      drive(vecs[i].op, vecs[i].src, vecs[i].r1, vecs[i].r2, vecs[i].im, vecs[i].sh,
            vecs[i].sa, vecs[i].sb, vecs[i].f1, vecs[i].f2);
      #1;
      chk($sformatf("vec%0d_equal", i), {31'd0, equal}, {31'd0, vecs[i].exp_eq});
      @(posedge CLK); #1;
      chk($sformatf("vec%0d_aluout", i), aluout_next, vecs[i].exp_alu);
      chk($sformatf("vec%0d_regwr", i), {31'd0, regwr_next}, 32'd1);
      chk($sformatf("vec%0d_npc", i), npc_next, 32'h1000 + 32'(i) * 4);
      chk($sformatf("vec%0d_wdat", i), wdat_next, fwd(vecs[i].sb, vecs[i].r2, vecs[i].f1, vecs[i].f2));
      chk($sformatf("vec%0d_regdst", i), {27'd0, regdst_next}, 32'(i));
    end

    // Hold with ihit=0
    ihit = 1'b0;
    drive(ALU_ADD, SRC_REG, 32'd100, 32'd200, 0, 0, 0, 0, 0, 0);
    npc = 32'h5555;
    @(posedge CLK); #1;
    chk("hold_aluout", aluout_next, 32'h5634);
    chk("hold_npc", npc_next, 32'h1000 + 11 * 4);

    // flush wins over ihit
    ihit = 1'b1; flush = 1'b1;
    @(posedge CLK); #1;
    chk("flush_aluout", aluout_next, 32'd0);
    chk("flush_npc", npc_next, 32'd0);
    chk("flush_regwr", {31'd0, regwr_next}, 32'd0);
    chk("flush_wdat", wdat_next, 32'd0);
    flush = 1'b0;

    // Async reset mid-cycle
    @(posedge CLK); #1;
    chk("pre_rst_aluout", aluout_next, 32'd300);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_aluout", aluout_next, 32'd0);
    chk("async_rst_npc", npc_next, 32'd0);
    chk("async_rst_regwr", {31'd0, regwr_next}, 32'd0);
    #1 RST = 1'b0;
    @(posedge CLK); #1;

`ifdef EXEC_MULT_EN
    // Multiply: 0x00010003 * 5
    ihit = 1'b1; flush = 1'b0; regwr = 1'b1; npc = 32'h2000;
    drive(ALU_MUL, SRC_REG, 32'h00010003, 32'h5, 0, 0, 0, 0, 0, 0);
    #1;
    busy_cycles = 0; bubble_ok = 1'b1;
    while (ex_busy && busy_cycles < 100) begin
      busy_cycles++;
      @(posedge CLK); #1;
      if (regwr_next !== 1'b0) bubble_ok = 1'b0;
    end
    chk("mul_busy_cycles", 32'(busy_cycles), 32'd33);
    chk("mul_bubble_regwr", {31'd0, bubble_ok}, 32'd1);
    @(posedge CLK); #1;
    chk("mul_result", aluout_next, 32'h0005000F);
    chk("mul_regwr", {31'd0, regwr_next}, 32'd1);
    chk("mul_npc", npc_next, 32'h2000);

    // Back-to-back MUL: 7 * 6
    npc = 32'h2004;
    drive(ALU_MUL, SRC_REG, 32'd7, 32'd6, 0, 0, 0, 0, 0, 0);
    #1;
    chk("b2b_busy_start", {31'd0, ex_busy}, 32'd1);
    busy_cycles = 0;
    while (ex_busy && busy_cycles < 100) begin
      busy_cycles++;
      @(posedge CLK); #1;
    end
    chk("b2b_busy_cycles", 32'(busy_cycles), 32'd33);
    @(posedge CLK); #1;
    chk("b2b_result", aluout_next, 32'd42);

    // Flush during MUL
    npc = 32'h3000;
    drive(ALU_MUL, SRC_REG, 32'd3, 32'd3, 0, 0, 0, 0, 0, 0);
    repeat (10) @(posedge CLK);
    #1;
    flush = 1'b1;
    #1;
    chk("mulflush_busy_before", {31'd0, ex_busy}, 32'd1);
    @(posedge CLK); #1;
    chk("mulflush_busy_after", {31'd0, ex_busy}, 32'd0);
    chk("mulflush_aluout", aluout_next, 32'd0);
    chk("mulflush_npc", npc_next, 32'd0);
    chk("mulflush_regwr", {31'd0, regwr_next}, 32'd0);
    flush = 1'b0;
    drive(ALU_ADD, SRC_REG, 32'd2, 32'd3, 0, 0, 0, 0, 0, 0);
    @(posedge CLK); #1;
    chk("mulflush_next_add", aluout_next, 32'd5);
`else
    // Without the multiplier, MUL is a single-cycle zero result
    ihit = 1'b1; flush = 1'b0; regwr = 1'b1; npc = 32'h2000;
    drive(ALU_MUL, SRC_REG, 32'h00010003, 32'h5, 0, 0, 0, 0, 0, 0);
    #1;
    chk("nomul_busy", {31'd0, ex_busy}, 32'd0);
    @(posedge CLK); #1;
    chk("nomul_result", aluout_next, 32'd0);
    chk("nomul_regwr", {31'd0, regwr_next}, 32'd1);
`endif

    // Randomized against the model
    exp_alu = '0; exp_wdat = '0; exp_npc = '0; exp_regwr = 1'b0;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] r1, r2, im, f1, f2;
      logic [1:0]  sa, sb;
      logic [4:0]  sh;
      aluop_t      op;
      alusrc_t     src;
      op  = rops[$urandom_range(0, 9)];
      src = ($urandom_range(0, 1) == 0) ? SRC_REG : SRC_IMM;
      r1 = $urandom; r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      im = $urandom; f1 = $urandom; f2 = $urandom;
      sa = 2'($urandom_range(0, 3)); sb = 2'($urandom_range(0, 3));
      sh = 5'($urandom_range(0, 31));
      ih = ($urandom_range(0, 4) != 0);
      fl = (i == 0) || ($urandom_range(0, 9) == 0);
      ihit = ih; flush = fl;
      npc = $urandom; regwr = 1'($urandom_range(0, 1));
      drive(op, src, r1, r2, im, sh, sa, sb, f1, f2);
      ea  = fwd(sa, r1, f1, f2);
      eb  = fwd(sb, r2, f1, f2);
      ebo = (src == SRC_IMM) ? im : eb;
      #1;
      chk("rnd_equal", {31'd0, equal}, {31'd0, ea == eb});
      chk("rnd_busy", {31'd0, ex_busy}, 32'd0);
      if (fl) begin
        exp_alu = '0; exp_wdat = '0; exp_npc = '0; exp_regwr = 1'b0;
      end else if (ih) begin
        exp_alu = model_alu(op, ea, ebo, eb, sh);
        exp_wdat = eb; exp_npc = npc; exp_regwr = regwr;
      end
      @(posedge CLK); #1;
      chk("rnd_aluout", aluout_next, exp_alu);
      chk("rnd_wdat", wdat_next, exp_wdat);
      chk("rnd_npc", npc_next, exp_npc);
      chk("rnd_regwr", {31'd0, regwr_next}, {31'd0, exp_regwr});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Parametrised execute stage for the pipelined MIPS datapath: operand forwarding from NFWD sources, ALU, branch-equal compare, and the registered EX/MEM latch with flush and stall control. It sits between the ID/EX latch and the memory stage. It adds an optional iterative multiplier whose busy signal stalls the front of the pipeline.

## Interface
Parameters:
- WORD_W, 32, datapath width
- SHAM_W, 5, shift-amount width
- NFWD, 2, number of forwarding sources (MEM, WB, ...)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- ihit  in  1  pipeline advance enable
- flush  in  1  load a bubble into EX/MEM
- npc, dren, dwen, regwr, regsel, regdst  in  WORD_W/1/1/1/regsel_t/regbit_t  pass-through from ID/EX
- rdat1, rdat2, imm  in  WORD_W  register operands, extended immediate
- shamt  in  SHAM_W  shift amount
- aluop  in  aluop_t  operation
- alusrc  in  alusrc_t  B-operand select: SRC_REG or SRC_IMM
- fwd_sel_a, fwd_sel_b  in  FSEL_W=$clog2(NFWD+1)  forward select per operand
- fwd_data  in  NFWD*WORD_W  forwarded values, slice k-1 is source k
- npc_next, dren_next, dwen_next, regwr_next, regsel_next, regdst_next  out  as inputs  latched pass-through
- aluout_next  out  WORD_W  latched result
- wdat_next  out  WORD_W  latched store data (forwarded B register value)
- equal  out  1  combinational; forwarded A == forwarded B
- ex_busy  out  1  combinational; multi-cycle op in progress, upstream must hold

## Operation
- Forwarding: sel 0 → rdatN. sel k, 1≤k≤NFWD → fwd_data slice k-1. sel > NFWD → rdatN.
- B operand: alusrc=SRC_IMM → imm, else forwarded rdat2.
- ALU ops, all modulo 2^WORD_W:
  - ADD, SUB, AND, OR, XOR, NOR.
  - SLT signed, SLTU unsigned; result 0 or 1.
  - SLL and SRL shift forwarded rdat2 by shamt.
- Latch update at posedge CLK, in priority order:
  - flush → all outputs 0.
  - else ihit && !ex_busy → load all outputs.
  - else ihit && ex_busy → bubble: regwr/dren/dwen = 0, other fields hold.
  - else hold.
- Reset: every latched output is 0; FSM is IDLE.
- Multiplier FSM (MULT_EN only):
  - IDLE: ex_busy = (aluop==ALU_MUL && !flush). On that condition, load multiplicand = A, multiplier = B, count = WORD_W-1, acc = 0, then go to MUL.
  - MUL: one shift-add per cycle, independent of ihit. At count==0 go to DONE.
  - DONE: ex_busy = 0; aluout = acc[WORD_W-1:0]. Go to IDLE when ihit or flush.
  - flush in MUL or DONE → IDLE at the next edge; the partial product is discarded.
  - Upstream must hold the ID/EX inputs stable while ex_busy=1.
  - Async RST at any point → IDLE with acc = 0.

## Timing
- ALU path: inputs → aluout_next, 1 cycle latency.
- equal is combinational, zero latency; it is used by the PC for branch resolution.
- ALU_MUL: ex_busy is high for WORD_W+1 cycles (the IDLE detect cycle plus WORD_W MUL cycles). The result is latched at the first edge in DONE with ihit=1.
- flush and ihit in the same cycle: flush wins.
- A back-to-back MUL re-enters MUL directly from IDLE on the cycle after DONE.

## Configuration
- EXEC_MULT_EN defined:
  - FSM and multiplier are present.
  - ALU_MUL behaves as above.
- EXEC_MULT_EN undefined:
  - No FSM; ex_busy is tied to 0.
  - ALU_MUL yields aluout 0 in a single cycle.

## Structure
- cpu_types_pkg holds:
  - aluop_t, which gains the ALU_MUL enumerator.
  - alusrc_t (SRC_REG, SRC_IMM).
  - word_t, regbit_t.
- control_unit_pkg holds regsel_t and the FSEL constant FWD_REG=0.
- FSM state enum exec_state_t {IDLE, MUL, DONE} is local to the module.
- Sub-module alu: combinational, takes a, b, shamt, aluop and returns result.

## Test plan
- ADD: rdat1=5, rdat2=7, alusrc=SRC_REG, ihit=1 → next cycle aluout_next=12, regwr_next follows input.
- Forwarding: fwd_sel_a=2, fwd_data slice1=0xDEAD0000, rdat1=0 → SUB result uses 0xDEAD0000. With fwd_sel_a=3 (>NFWD), rdat1 is used.
- SLT: A=0xFFFFFFFF, B=1 → 1. SLTU on the same operands → 0. equal=1 when A==B=0x10.
- flush with ihit=1 → all latched outputs 0. RST mid-op → outputs 0 asynchronously.
- MUL (EXEC_MULT_EN): A=0x0001_0003, B=0x0000_0005:
  - ex_busy high for 33 cycles.
  - Latched regwr_next=0 throughout.
  - Then aluout_next=0x0005_000F.
- Flush during MUL at cycle 10 → ex_busy drops next cycle, FSM IDLE, latch zeroed, no result written.
